// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_drain
// Brief    : Pops entries from an upstream circular buffer and serialises
//            each one as an asynchronous UART frame on TXD.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
    parameter int DATAWIDTH    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNTSIZE      = 16,
    parameter int STOPBITS     = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ENABLE,
    input  logic                 BUF_ISEMPTY,
    input  logic [DATAWIDTH-1:0] BUF_RDDATA,
    output logic                 BUF_READ,
    output logic                 TXD,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int                  c_BITW      = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [CNTSIZE-1:0]  c_LAST_CNT  = CNTSIZE'(CLKS_PER_BIT - 1);
    localparam logic [c_BITW-1:0]   c_LAST_BIT  = c_BITW'(DATAWIDTH - 1);
    localparam logic                c_LAST_STOP = (STOPBITS == 2);
    localparam logic                c_ODD       = (PARITY_ODD != 0);
    localparam logic                c_PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [DATAWIDTH-1:0] r_shift,   w_shift_nxt;
    logic                 r_par,     w_par_nxt;
    logic [c_BITW-1:0]    r_bitcnt,  w_bitcnt_nxt;
    logic [CNTSIZE-1:0]   r_cnt,     w_cnt_nxt;
    logic                 r_stopcnt, w_stopcnt_nxt;
    logic                 r_read,    w_read_nxt;
    logic                 r_done,    w_done_nxt;
    logic                 w_bit_end;
    logic                 w_txd;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_bitcnt  <= '0;
            r_cnt     <= '0;
            r_stopcnt <= 1'b0;
            r_read    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stopcnt <= w_stopcnt_nxt;
            r_read    <= w_read_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_bitcnt_nxt  = r_bitcnt;
        w_cnt_nxt     = r_cnt;
        w_stopcnt_nxt = r_stopcnt;
        w_read_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_txd         = 1'b1;
        w_bit_end     = (r_cnt == c_LAST_CNT);

        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNTSIZE'(1);
        end

        case (r_state)
            S_IDLE: begin
                // TXD is decoded from state, so it drops on the same edge as the pop
                if (ENABLE && !BUF_ISEMPTY) begin
                    w_state_nxt   = S_START;
                    w_shift_nxt   = BUF_RDDATA;
                    w_par_nxt     = (^BUF_RDDATA) ^ c_ODD;
                    w_read_nxt    = 1'b1;
                    w_bitcnt_nxt  = '0;
                    w_cnt_nxt     = '0;
                    w_stopcnt_nxt = 1'b0;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bitcnt == c_LAST_BIT) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = c_PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + c_BITW'(1);
                    end
                end
            end
            S_PARITY: begin
                w_txd = r_par;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_txd = 1'b1;
                if (w_bit_end) begin
                    if (r_stopcnt == c_LAST_STOP) begin
                        w_stopcnt_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_stopcnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign TXD        = w_txd;
    assign BUSY       = (r_state != S_IDLE);
    assign BUF_READ   = r_read;
    assign FRAME_DONE = r_done;

endmodule
`default_nettype wire
